// File: rtl/uart_alu_ctrl.sv
// Command sequencer between uart_rx, the ALU and uart_tx: gathers A, B and OP bytes, latches the ALU result and fires one TX start.
// Optional inter-byte timeout is compiled in with macro UART_ALU_CTRL_TIMEOUT_EN.
module uart_alu_ctrl #(
    parameter int NB_DATA        = 8,
    parameter int NB_OP          = 6,
    parameter int TIMEOUT_CYCLES = 50000,
    parameter int NB_TIMEOUT     = 16
) (
    input  logic               i_clock,
    input  logic               i_reset,
    input  logic [NB_DATA-1:0] i_rx_data,
    input  logic               i_rx_done,
    input  logic               i_rx_frame_valid,
    input  logic [NB_DATA-1:0] i_alu_result,
    input  logic               i_tx_busy,
    input  logic               i_tx_done,
    output logic [NB_DATA-1:0] o_alu_a,
    output logic [NB_DATA-1:0] o_alu_b,
    output logic [NB_OP-1:0]   o_alu_op,
    output logic [NB_DATA-1:0] o_tx_data,
    output logic               o_tx_start,
    output logic               o_busy,
    output logic               o_overrun,
    output logic               o_frame_err,
    output logic               o_timeout
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        GET_B   = 3'd1,
        GET_OP  = 3'd2,
        EXEC    = 3'd3,
        SEND    = 3'd4,
        WAIT_TX = 3'd5
    } state_t;

    // A counter too narrow to reach TIMEOUT_CYCLES-1 would never expire.
    if (NB_TIMEOUT < $clog2(TIMEOUT_CYCLES)) begin : g_cfgCheck
        $error("uart_alu_ctrl: NB_TIMEOUT too small for TIMEOUT_CYCLES");
    end

    state_t               r_state;
    state_t               w_nextState;
    logic [NB_DATA-1:0]   r_aluA;
    logic [NB_DATA-1:0]   w_aluA;
    logic [NB_DATA-1:0]   r_aluB;
    logic [NB_DATA-1:0]   w_aluB;
    logic [NB_OP-1:0]     r_aluOp;
    logic [NB_OP-1:0]     w_aluOp;
    logic [NB_DATA-1:0]   r_txData;
    logic [NB_DATA-1:0]   w_txData;
    logic                 r_txStart;
    logic                 w_txStart;
    logic                 r_overrun;
    logic                 w_overrun;
    logic                 r_frameErr;
    logic                 w_frameErr;
    logic                 w_accepted;
`ifdef UART_ALU_CTRL_TIMEOUT_EN
    logic [NB_TIMEOUT-1:0] r_timeoutCount;
    logic [NB_TIMEOUT-1:0] w_timeoutCount;
    logic                  r_timeout;
    logic                  w_timeout;
`endif

    assign w_accepted = i_rx_done & i_rx_frame_valid;

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_state    <= IDLE;
            r_aluA     <= '0;
            r_aluB     <= '0;
            r_aluOp    <= '0;
            r_txData   <= '0;
            r_txStart  <= 1'b0;
            r_overrun  <= 1'b0;
            r_frameErr <= 1'b0;
        end else begin
            r_state    <= w_nextState;
            r_aluA     <= w_aluA;
            r_aluB     <= w_aluB;
            r_aluOp    <= w_aluOp;
            r_txData   <= w_txData;
            r_txStart  <= w_txStart;
            r_overrun  <= w_overrun;
            r_frameErr <= w_frameErr;
        end
    end

`ifdef UART_ALU_CTRL_TIMEOUT_EN
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_timeoutCount <= '0;
            r_timeout      <= 1'b0;
        end else begin
            r_timeoutCount <= w_timeoutCount;
            r_timeout      <= w_timeout;
        end
    end
`endif

    // Only the operand register belonging to the current state is ever written.
    always_comb begin
        w_nextState = r_state;
        w_aluA      = r_aluA;
        w_aluB      = r_aluB;
        w_aluOp     = r_aluOp;
        w_txData    = r_txData;
        w_txStart   = 1'b0;
        w_overrun   = r_overrun;
        w_frameErr  = i_rx_done & ~i_rx_frame_valid;

        case (r_state)
            IDLE: begin
                if (w_accepted) begin
                    w_aluA      = i_rx_data;
                    w_nextState = GET_B;
                end
            end
            GET_B: begin
                if (w_accepted) begin
                    w_aluB      = i_rx_data;
                    w_nextState = GET_OP;
                end
            end
            GET_OP: begin
                if (w_accepted) begin
                    w_aluOp     = i_rx_data[NB_OP-1:0];
                    w_nextState = EXEC;
                end
            end
            EXEC: begin
                w_txData    = i_alu_result;
                w_nextState = SEND;
                if (i_rx_done) w_overrun = 1'b1;
            end
            SEND: begin
                if (!i_tx_busy) begin
                    w_txStart   = 1'b1;
                    w_nextState = WAIT_TX;
                end
                if (i_rx_done) w_overrun = 1'b1;
            end
            WAIT_TX: begin
                if (i_tx_done) w_nextState = IDLE;
                if (i_rx_done) w_overrun = 1'b1;
            end
            default: w_nextState = IDLE;
        endcase

`ifdef UART_ALU_CTRL_TIMEOUT_EN
        // A byte arriving on the expiry cycle takes priority over the abort.
        w_timeout      = 1'b0;
        w_timeoutCount = '0;
        if ((r_state == GET_B) || (r_state == GET_OP)) begin
            if (w_accepted) begin
                w_timeoutCount = '0;
            end else if (r_timeoutCount == NB_TIMEOUT'(TIMEOUT_CYCLES - 1)) begin
                w_nextState    = IDLE;
                w_timeout      = 1'b1;
                w_timeoutCount = '0;
            end else begin
                w_timeoutCount = r_timeoutCount + 1'b1;
            end
        end
`endif
    end

    assign o_alu_a     = r_aluA;
    assign o_alu_b     = r_aluB;
    assign o_alu_op    = r_aluOp;
    assign o_tx_data   = r_txData;
    assign o_tx_start  = r_txStart;
    assign o_busy      = (r_state != IDLE);
    assign o_overrun   = r_overrun;
    assign o_frame_err = r_frameErr;
`ifdef UART_ALU_CTRL_TIMEOUT_EN
    assign o_timeout   = r_timeout;
`else
    assign o_timeout   = 1'b0;
`endif

endmodule
